fp_mean_cov_axil_slave: RTL and testbench
=========================================

Name: fp_mean_cov_axil_slave

Overview:
AXI4-Lite responder that fronts the FP mean/covariance core. It is the slave end of the AXI VIP master used in the block-design bench. It decodes four 32-bit registers (CTRL, DATA_IN, STATUS, RESULT), streams written samples to the core with a valid/ready handshake, and exposes core status, result and an interrupt.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width. Offsets 0x10-0x3C are unmapped.

Ports:
S_AXI_ACLK  in  1  single clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR/3/1/1  write address channel; AWPROT is ignored
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR/3/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
start_o  out  1  one-cycle start pulse to the core
sample_data_o  out  32  FP32 sample to the core
sample_valid_o  out  1  asserted while a sample is pending
sample_ready_i  in  1  core accepts the sample
busy_i  in  1  core busy level
done_i  in  1  one-cycle completion pulse from the core
result_i  in  32  core result word
irq_o  out  1  interrupt = CTRL.IRQ_EN & STATUS.DONE

Behaviour:
- Reset (asynchronous assert, synchronous release): all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, start_o 0, sample_valid_o 0, sample_data_o 0, CTRL 0, DONE 0, sample count 0, irq_o 0.
- Reset asserted mid-transaction aborts it; no B or R beat is issued after release.

Write path:
- Accept a write when AWVALID & WVALID & !BVALID and no stall. On acceptance, AWREADY and WREADY pulse together for 1 cycle.
- BVALID rises on the cycle after acceptance and is held until BREADY. No new write is accepted while BVALID is high.
- Stall: a write decoded to DATA_IN while sample_valid_o=1 is not accepted until the sample handshake completes.
- WSTRB applies per byte to CTRL and DATA_IN. A write to DATA_IN with WSTRB=0 updates nothing and pushes no sample.

Register map (addresses word-aligned; ADDR[1:0] ignored):
- 0x00 CTRL, RW.
  - bit0 START: writing 1 drives start_o=1 for exactly one cycle, the cycle after acceptance; the bit always reads 0.
  - bit1 IRQ_EN: RW.
  - bit2 CLR: write-1 clears the sample count and DONE; reads 0.
- 0x04 DATA_IN.
  - A write latches the byte-masked data into sample_data_o and sets sample_valid_o the cycle after acceptance.
  - sample_valid_o clears on the cycle where sample_valid_o & sample_ready_i; the sample count increments on that same cycle.
  - Reads return the last latched value.
- 0x08 STATUS.
  - bit0 BUSY = busy_i (RO).
  - bit1 DONE: sticky, set by done_i, write-1-to-clear.
  - bit2 PENDING = sample_valid_o (RO).
  - bits[15:8] sample count: 8-bit, saturates at 255.
  - Writes to other bits are ignored.
- 0x0C RESULT: RO, returns result_i sampled at read acceptance. Writes get OKAY and have no effect.
- Unmapped offsets: write gets BRESP=SLVERR (2'b10) with no side effects; read gets RDATA=0, RRESP=SLVERR.
- Simultaneous DONE set (done_i) and W1C on the same cycle: set wins.
- CLR coincident with a sample handshake: count ends at 0.

Read path:
- Accept when ARVALID & !RVALID; ARREADY pulses 1 cycle.
- RDATA/RRESP are registered; RVALID rises the next cycle and is held stable until RREADY.
- Read and write channels are independent and may complete in the same cycle.

irq_o is registered, so it lags the DONE/IRQ_EN change by 1 cycle.

Decomposition:
- Package fp_mean_cov_axil_pkg holds:
  - register offset localparams (ADDR_CTRL=4'h0, ADDR_DATA_IN=4'h4, ADDR_STATUS=4'h8, ADDR_RESULT=4'hC);
  - CTRL/STATUS bit-index constants;
  - resp typedef with RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- No sub-module: the write FSM (IDLE, RESP), read FSM (IDLE, DATA) and register bank fit one module of about 250 lines.

Test Plan:
1. Reset: hold ARESETN low for 100 ns, then release → all outputs 0; read 0x08 returns 0x00000000 with OKAY.
2. Write 0x00=0x00000003 → start_o high exactly 1 cycle; BRESP=OKAY; read 0x00 returns 0x00000002.
3. Write 0x04=0x3F800000 with sample_ready_i held low 10 cycles; a second write 0x04=0x40000000 is issued meanwhile:
   - second AWREADY is withheld until the first handshake;
   - the core sees 0x3F800000 then 0x40000000;
   - STATUS[15:8]=2.
4. Pulse done_i with IRQ_EN=1 → irq_o=1 one cycle later; STATUS reads 0x...02 (plus count); write 0x08=0x2 → DONE=0, irq_o=0. Repeat with done_i coincident with the W1C → DONE stays 1.
5. Read 0x10 and write 0x3C=0xFFFFFFFF → RRESP=BRESP=2'b10, RDATA=0, no register changes.
6. Backpressure: hold BREADY/RREADY low for 5 cycles → BVALID/RVALID and RDATA stay stable; no extra acceptance occurs; result_i=0x40490FDB is read back exactly.

Source files
------------

// File: rtl/fp_mean_cov_axil_pkg.sv
// Shared register map, bit positions and response codes for the FP mean/covariance
// AXI4-Lite register front end.
package fp_mean_cov_axil_pkg;

    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_DATA_IN = 4'h4;
    localparam logic [3:0] ADDR_STATUS  = 4'h8;
    localparam logic [3:0] ADDR_RESULT  = 4'hC;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_CLR    = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_PENDING = 2;
    localparam int unsigned STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

endpackage

// File: rtl/fp_mean_cov_axil_slave.sv
// AXI4-Lite responder for the FP mean/covariance core: CTRL, DATA_IN, STATUS and RESULT
// registers, a valid/ready sample stream to the core, and a registered interrupt.
import fp_mean_cov_axil_pkg::*;

module fp_mean_cov_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          start_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] sample_data_o,
    output logic                          sample_valid_o,
    input  logic                          sample_ready_i,
    input  logic                          busy_i,
    input  logic                          done_i,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] result_i,
    output logic                          irq_o
);

    typedef enum logic {StWrIdle, StWrResp} wr_state_e;
    typedef enum logic {StRdIdle, StRdData} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic awready_q, awready_d;
    logic arready_q, arready_d;
    resp_e bresp_q, rresp_q, rd_resp;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rd_word;

    logic [C_S_AXI_DATA_WIDTH-1:0] sample_data_q;
    logic sample_valid_q;
    logic start_q;
    logic irq_en_q;
    logic done_q;
    logic irq_q;
    logic [7:0] count_q;

    logic [3:0] wr_off, rd_off;
    logic wr_mapped, rd_mapped, wr_is_data, wr_stall, wr_fire, rd_fire;
    logic wr_ctrl, ctrl_start, ctrl_clr, done_w1c, sample_hs;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_off     = {S_AXI_AWADDR[3:2], 2'b00};
    assign rd_off     = {S_AXI_ARADDR[3:2], 2'b00};
    assign wr_mapped  = (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4] == '0);
    assign rd_mapped  = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4] == '0);
    assign wr_is_data = wr_mapped && (wr_off == ADDR_DATA_IN);
    // A new sample may not overwrite one the core has not yet taken.
    assign wr_stall   = wr_is_data && sample_valid_q;
    assign wr_fire    = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire    = arready_q && S_AXI_ARVALID;

    assign wr_ctrl    = wr_fire && wr_mapped && (wr_off == ADDR_CTRL) && S_AXI_WSTRB[0];
    assign ctrl_start = wr_ctrl && S_AXI_WDATA[CTRL_START];
    assign ctrl_clr   = wr_ctrl && S_AXI_WDATA[CTRL_CLR];
    assign done_w1c   = wr_fire && wr_mapped && (wr_off == ADDR_STATUS) && S_AXI_WSTRB[0]
                        && S_AXI_WDATA[STAT_DONE];
    assign sample_hs  = sample_valid_q && sample_ready_i;

    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = 1'b0;
        unique case (wr_state_q)
            StWrIdle: begin
                if (wr_fire) begin
                    wr_state_d = StWrResp;
                end else if (!awready_q && S_AXI_AWVALID && S_AXI_WVALID && !wr_stall) begin
                    awready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = StWrIdle;
                end
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = 1'b0;
        unique case (rd_state_q)
            StRdIdle: begin
                if (rd_fire) begin
                    rd_state_d = StRdData;
                end else if (!arready_q && S_AXI_ARVALID) begin
                    arready_d = 1'b1;
                end
            end
            StRdData: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = StRdIdle;
                end
            end
        endcase
    end

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        if (!rd_mapped) begin
            rd_resp = RESP_SLVERR;
        end else begin
            case (rd_off)
                ADDR_CTRL:    rd_word[CTRL_IRQ_EN] = irq_en_q;
                ADDR_DATA_IN: rd_word = sample_data_q;
                ADDR_STATUS: begin
                    rd_word[STAT_BUSY]         = busy_i;
                    rd_word[STAT_DONE]         = done_q;
                    rd_word[STAT_PENDING]      = sample_valid_q;
                    rd_word[STAT_CNT_LSB +: 8] = count_q;
                end
                ADDR_RESULT:  rd_word = result_i;
                default:      rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q <= StWrIdle;
            rd_state_q <= StRdIdle;
            awready_q  <= 1'b0;
            arready_q  <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            arready_q  <= arready_d;
            if (wr_fire) begin
                bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end
            if (rd_fire) begin
                rdata_q <= rd_word;
                rresp_q <= rd_resp;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            start_q        <= 1'b0;
            irq_en_q       <= 1'b0;
            done_q         <= 1'b0;
            irq_q          <= 1'b0;
            count_q        <= '0;
        end else begin
            start_q <= ctrl_start;
            if (wr_ctrl) begin
                irq_en_q <= S_AXI_WDATA[CTRL_IRQ_EN];
            end
            if (wr_fire && wr_is_data) begin
                for (int b = 0; b < 4; b++) begin
                    if (S_AXI_WSTRB[b]) begin
                        sample_data_q[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    end
                end
            end
            if (wr_fire && wr_is_data && (S_AXI_WSTRB != 4'b0000)) begin
                sample_valid_q <= 1'b1;
            end else if (sample_hs) begin
                sample_valid_q <= 1'b0;
            end
            // CLR wins over a coincident handshake so the count ends at zero.
            if (ctrl_clr) begin
                count_q <= '0;
            end else if (sample_hs && (count_q != 8'hFF)) begin
                count_q <= count_q + 8'd1;
            end
            if (done_i) begin
                done_q <= 1'b1;
            end else if (ctrl_clr || done_w1c) begin
                done_q <= 1'b0;
            end
            irq_q <= irq_en_q & done_q;
        end
    end

    assign S_AXI_AWREADY  = awready_q;
    assign S_AXI_WREADY   = awready_q;
    assign S_AXI_BVALID   = (wr_state_q == StWrResp);
    assign S_AXI_BRESP    = bresp_q;
    assign S_AXI_ARREADY  = arready_q;
    assign S_AXI_RVALID   = (rd_state_q == StRdData);
    assign S_AXI_RDATA    = rdata_q;
    assign S_AXI_RRESP    = rresp_q;
    assign start_o        = start_q;
    assign sample_data_o  = sample_data_q;
    assign sample_valid_o = sample_valid_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_fp_mean_cov_axil_slave.sv
// Directed and randomized bench for fp_mean_cov_axil_slave against a register-level model.
module tb_fp_mean_cov_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        start_o, sample_valid_o, sample_ready_i, busy_i, done_i, irq_o;
    logic [31:0] sample_data_o, result_i;

    always #5 clk = ~clk;

    fp_mean_cov_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .start_o       (start_o),
        .sample_data_o (sample_data_o),
        .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i),
        .busy_i        (busy_i),
        .done_i        (done_i),
        .result_i      (result_i),
        .irq_o         (irq_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state, kept at register level.
    logic        m_irq_en = 1'b0;
    logic [31:0] m_data   = '0;
    int          m_count  = 0;
    logic        m_done   = 1'b0;
    int          m_starts = 0;
    logic [31:0] exp_q[$];

    // Bus/core observers.
    int          aw_fires = 0, ar_fires = 0, start_cnt = 0, start_wide = 0;
    logic        start_prev = 1'b0;
    logic [31:0] got_q[$];

    always @(posedge clk) begin
        if (awvalid && awready) aw_fires++;
        if (arvalid && arready) ar_fires++;
        if (start_o) start_cnt++;
        if (start_o && start_prev) start_wide++;
        start_prev = start_o;
        if (sample_valid_o && sample_ready_i) got_q.push_back(sample_data_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bound(input string tag, input int n);
        checks++;
        assert (n < 100) else begin
            errors++;
            $error("FAIL %s: waited %0d cycles, limit 100", tag, n);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        if (a[5:4] != 2'b00) return 32'h0;
        case (a[3:2])
            2'd0:    return {29'b0, m_irq_en, 1'b0};
            2'd1:    return m_data;
            2'd2:    return {16'b0, m_count[7:0], 5'b0, 1'b0, m_done, busy_i};
            default: return result_i;
        endcase
    endfunction

    function automatic logic [1:0] model_write(input logic [5:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        if (a[5:4] != 2'b00) return 2'b10;
        case (a[3:2])
            2'd0: if (s[0]) begin
                m_irq_en = d[1];
                if (d[0]) m_starts++;
                if (d[2]) begin m_count = 0; m_done = 1'b0; end
            end
            2'd1: if (s != 4'b0) begin
                for (int b = 0; b < 4; b++) if (s[b]) m_data[8*b +: 8] = d[8*b +: 8];
                exp_q.push_back(m_data);
                m_count = (m_count < 255) ? m_count + 1 : 255;
            end
            2'd2: if (s[0] && d[1]) m_done = 1'b0;
            default: ;
        endcase
        return 2'b00;
    endfunction

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = (hold == 0);
        n = 0;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        bound("aw_wait", n);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        bound("b_wait", n);
        resp = bresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 32'd1);
            check("bresp_hold", bresp, resp);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_drop", bvalid, 32'd0);
    endtask

    task automatic axi_read(input logic [5:0] a, input int hold,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        n = 0;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        bound("ar_wait", n);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 100) begin @(negedge clk); n++; end
        bound("r_wait", n);
        data = rdata; resp = rresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rvalid_hold", rvalid, 32'd1);
            check("rdata_hold", rdata, data);
            check("rresp_hold", rresp, resp);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_drop", rvalid, 32'd0);
    endtask

    task automatic read_check(input string tag, input logic [5:0] a);
        logic [31:0] d, e;
        logic [1:0]  r;
        e = model_read(a);
        axi_read(a, 0, d, r);
        check(tag, d, e);
        check({tag, "_resp"}, r, (a[5:4] != 2'b00) ? 32'd2 : 32'd0);
    endtask

    initial begin
        logic [31:0] d, d2;
        logic [1:0]  r, r2;
        logic [3:0]  s;
        int          cnt0, aw0, ar0, n2, op;

        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0;
        sample_ready_i = 0; busy_i = 0; done_i = 0; result_i = '0;

        // Reset
        #100;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ctl", {awready, wready, bvalid, bresp, arready, rvalid, rresp,
                          start_o, sample_valid_o, irq_o}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_sdata", sample_data_o, 32'd0);
        read_check("rst_status", 6'h08);

        // START + IRQ_EN
        axi_write(6'h00, 32'h3, 4'hF, 0, r);
        check("ctrl_bresp", r, model_write(6'h00, 32'h3, 4'hF));
        check("start_cnt", start_cnt, m_starts);
        check("start_wide", start_wide, 32'd0);
        read_check("ctrl_rd", 6'h00);

        // Sample stall while core withholds ready
        cnt0 = m_count;
        axi_write(6'h04, 32'h3F80_0000, 4'hF, 0, r);
        check("data1_bresp", r, model_write(6'h04, 32'h3F80_0000, 4'hF));
        axi_read(6'h08, 0, d, r);
        check("status_pending", d, {16'b0, cnt0[7:0], 8'h04});
        aw0 = aw_fires;
        fork
            axi_write(6'h04, 32'h4000_0000, 4'hF, 0, r2);
            begin
                repeat (10) @(negedge clk);
                check("stall_aw", aw_fires, aw0);
                check("stall_valid", sample_valid_o, 32'd1);
                check("stall_data", sample_data_o, 32'h3F80_0000);
                sample_ready_i = 1'b1;
            end
        join
        check("data2_bresp", r2, model_write(6'h04, 32'h4000_0000, 4'hF));
        @(negedge clk);
        check("core_s1", got_q[got_q.size()-2], 32'h3F80_0000);
        check("core_s2", got_q[got_q.size()-1], 32'h4000_0000);
        read_check("status_cnt2", 6'h08);

        // DONE / interrupt timing and W1C
        @(negedge clk); done_i = 1'b1;
        @(negedge clk); done_i = 1'b0;
        m_done = 1'b1;
        check("irq_lag", irq_o, 32'd0);
        @(negedge clk);
        check("irq_set", irq_o, 32'd1);
        read_check("status_done", 6'h08);
        axi_write(6'h08, 32'h2, 4'hF, 0, r);
        check("w1c_bresp", r, model_write(6'h08, 32'h2, 4'hF));
        check("irq_clr", irq_o, 32'd0);
        read_check("status_w1c", 6'h08);
        fork
            axi_write(6'h08, 32'h2, 4'hF, 0, r);
            begin
                n2 = 0;
                @(negedge clk);
                while (!awready && n2 < 100) begin @(negedge clk); n2++; end
                done_i = 1'b1;
                @(negedge clk);
                done_i = 1'b0;
            end
        join
        void'(model_write(6'h08, 32'h2, 4'hF));
        m_done = 1'b1;
        read_check("status_setwins", 6'h08);
        check("irq_setwins", irq_o, 32'd1);
        axi_write(6'h00, 32'h6, 4'hF, 0, r);
        void'(model_write(6'h00, 32'h6, 4'hF));
        read_check("status_clr", 6'h08);
        check("irq_after_clr", irq_o, 32'd0);

        // Unmapped offsets
        read_check("unmapped_rd", 6'h10);
        axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 0, r);
        check("unmapped_bresp", r, model_write(6'h3C, 32'hFFFF_FFFF, 4'hF));
        read_check("after_unm_ctrl", 6'h00);
        read_check("after_unm_data", 6'h04);
        read_check("after_unm_status", 6'h08);

        // Backpressure on both response channels
        result_i = 32'h4049_0FDB;
        ar0 = ar_fires;
        fork
            axi_read(6'h0C, 5, d, r);
            begin repeat (4) @(negedge clk); result_i = 32'hDEAD_BEEF; end
        join
        check("result_bp", d, 32'h4049_0FDB);
        check("result_bp_resp", r, 32'd0);
        check("ar_once", ar_fires, ar0 + 1);
        aw0 = aw_fires;
        axi_write(6'h00, 32'h2, 4'hF, 5, r);
        check("bp_bresp", r, model_write(6'h00, 32'h2, 4'hF));
        check("aw_once", aw_fires, aw0 + 1);

        // Concurrent read and write
        result_i = 32'h1234_5678;
        fork
            axi_write(6'h04, 32'hCAFE_F00D, 4'hF, 0, r);
            axi_read(6'h0C, 0, d2, r2);
        join
        check("conc_bresp", r, model_write(6'h04, 32'hCAFE_F00D, 4'hF));
        check("conc_rdata", d2, 32'h1234_5678);

        // Randomized register traffic
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 4);
            busy_i = 1'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            case (op)
                0: begin
                    axi_write(6'h04, d, s, 0, r);
                    check("rnd_data_bresp", r, model_write(6'h04, d, s));
                end
                1: read_check("rnd_status", 6'(8 + $urandom_range(0, 3)));
                2: read_check("rnd_data", 6'h04);
                3: begin result_i = d; read_check("rnd_result", 6'h0C); end
                default: begin
                    axi_write(6'h00, d, s, 0, r);
                    check("rnd_ctrl_bresp", r, model_write(6'h00, d, s));
                    read_check("rnd_ctrl", 6'h00);
                end
            endcase
            check("rnd_irq", irq_o, {31'b0, m_irq_en & m_done});
        end
        busy_i = 1'b0;

        // Sample count saturation
        for (int i = 0; i < 256; i++) begin
            axi_write(6'h04, 32'(i), 4'hF, 0, r);
            void'(model_write(6'h04, 32'(i), 4'hF));
        end
        read_check("status_sat", 6'h08);

        check("samples_n", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) check("sample_seq", got_q[i], exp_q[i]);
        end
        check("start_total", start_cnt, m_starts);
        check("start_width", start_wide, 32'd0);

        // Reset while a write response is outstanding
        @(negedge clk);
        awaddr = 6'h00; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        n2 = 0;
        while (!awready && n2 < 100) begin @(negedge clk); n2++; end
        bound("rst_aw_wait", n2);
        @(negedge clk);
        rst_n = 1'b0; awvalid = 0; wvalid = 0;
        #1;
        check("rst_bvalid", bvalid, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; bready = 1'b1;
        m_irq_en = 0; m_data = '0; m_count = 0; m_done = 0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_beats", {bvalid, rvalid}, 32'd0);
        end
        bready = 1'b0;
        read_check("post_rst_ctrl", 6'h00);
        read_check("post_rst_status", 6'h08);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
